hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and pipeline-control unit for the 5-stage ARM datapath (F, D, E, M, W). It keeps its own shadow of the D/E/M/W destination-register and control bits. From that shadow it generates per-operand forwarding selects, load-use stalls, PC-write and branch flushes, and a whole-pipe freeze for slow memory. It replaces the datapath's raw `match` vector and fixed two-operand forwarding with a self-contained block, generalised in register count and number of read ports, plus a stall-cycle counter.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and pipeline-control unit for the 5-stage F/D/E/M/W datapath.
// Keeps a shadow of D/E/M/W control bits and derives forwarding, stalls, flushes and a stall counter.
module hazard_ctrl #(
  parameter int NREG   = 16,
  parameter int NRD    = 2,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr_d,
  input  logic [NRD-1:0]      rd_en_d,
  input  logic [AW-1:0]       wr_addr_d,
  input  logic                wr_en_d,
  input  logic                mem_to_reg_d,
  input  logic                pc_wr_d,
  input  logic                branch_taken_e,
  input  logic                mem_wait,
  input  logic                clr_cnt,
  output logic [NRD*2-1:0]    fwd_sel,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic                stall_emw,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [AW-1:0] PC_A = AW'(PC_REG);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // p0 = D, p1 = E, p2 = M, p3 = W
  logic              r_vld_p0;
  logic              r_vld_p1, r_we_p1, r_ld_p1, r_pcw_p1;
  logic [AW-1:0]     r_wa_p1;
  logic [NRD*AW-1:0] r_ra_p1;
  logic [NRD-1:0]    r_re_p1;
  logic              r_vld_p2, r_we_p2, r_ld_p2, r_pcw_p2;
  logic [AW-1:0]     r_wa_p2;
  logic              r_vld_p3, r_we_p3, r_pcw_p3;
  logic [AW-1:0]     r_wa_p3;
  logic [CNT_W-1:0]  r_cnt;

  logic w_ld_hit, w_ld_stall, w_pc_pend, w_bte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_we_p1  <= 1'b0;
      r_ld_p1  <= 1'b0;
      r_pcw_p1 <= 1'b0;
      r_wa_p1  <= '0;
      r_ra_p1  <= '0;
      r_re_p1  <= '0;
      r_vld_p2 <= 1'b0;
      r_we_p2  <= 1'b0;
      r_ld_p2  <= 1'b0;
      r_pcw_p2 <= 1'b0;
      r_wa_p2  <= '0;
      r_vld_p3 <= 1'b0;
      r_we_p3  <= 1'b0;
      r_pcw_p3 <= 1'b0;
      r_wa_p3  <= '0;
    end else if (!mem_wait) begin
      // D: flush beats stall
      if (flush_d)       r_vld_p0 <= 1'b0;
      else if (!stall_d) r_vld_p0 <= 1'b1;
      // E
      r_vld_p1 <= r_vld_p0 & ~flush_e;
      r_we_p1  <= wr_en_d;
      r_ld_p1  <= mem_to_reg_d;
      r_pcw_p1 <= pc_wr_d;
      r_wa_p1  <= wr_addr_d;
      r_ra_p1  <= rd_addr_d;
      r_re_p1  <= rd_en_d;
      // M
      r_vld_p2 <= r_vld_p1;
      r_we_p2  <= r_we_p1;
      r_ld_p2  <= r_ld_p1;
      r_pcw_p2 <= r_pcw_p1;
      r_wa_p2  <= r_wa_p1;
      // W
      r_vld_p3 <= r_vld_p2;
      r_we_p3  <= r_we_p2;
      r_pcw_p3 <= r_pcw_p2;
      r_wa_p3  <= r_wa_p2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_cnt <= '0;
    else if (clr_cnt) r_cnt <= '0;
    else if (stall_f) r_cnt <= sat_inc(r_cnt);
  end

  always_comb begin
    w_ld_hit = 1'b0;
    for (int i = 0; i < NRD; i++)
      if (rd_en_d[i] && (rd_addr_d[i*AW +: AW] == r_wa_p1)) w_ld_hit = 1'b1;
  end

  // PC_REG reads always come from the register file, whose PC view the datapath supplies
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NRD; i++) begin
      if (r_vld_p1 && r_re_p1[i] && (r_ra_p1[i*AW +: AW] != PC_A)) begin
        if (r_vld_p2 && r_we_p2 && !r_ld_p2 && (r_wa_p2 == r_ra_p1[i*AW +: AW]))
          fwd_sel[i*2 +: 2] = 2'b10;
        else if (r_vld_p3 && r_we_p3 && (r_wa_p3 == r_ra_p1[i*AW +: AW]))
          fwd_sel[i*2 +: 2] = 2'b01;
      end
    end
  end

  assign w_ld_stall = r_vld_p1 & r_we_p1 & r_ld_p1 & r_vld_p0 & w_ld_hit;
  assign w_pc_pend  = (r_vld_p0 & pc_wr_d) | (r_vld_p1 & r_pcw_p1) | (r_vld_p2 & r_pcw_p2);
  assign w_bte      = branch_taken_e & r_vld_p1;

  assign stall_f   = w_ld_stall | w_pc_pend | mem_wait;
  assign stall_d   = w_ld_stall | mem_wait;
  assign stall_emw = mem_wait;
  assign flush_d   = ~mem_wait & (w_pc_pend | (r_vld_p3 & r_pcw_p3) | w_bte);
  assign flush_e   = ~mem_wait & (w_ld_stall | w_bte);
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl: one table row per clock cycle,
// followed by hand-written counter-saturation and mid-run reset sequences.
module tb_hazard_ctrl;
  localparam int AW = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [2*AW-1:0] rd_addr_d;
  logic [1:0]    rd_en_d;
  logic [AW-1:0] wr_addr_d;
  logic          wr_en_d, mem_to_reg_d, pc_wr_d, branch_taken_e, mem_wait, clr_cnt;
  logic [3:0]    fwd_sel;
  logic          stall_f, stall_d, flush_d, flush_e, stall_emw;
  logic [CW-1:0] stall_cnt;
  logic [4:0]    flg;

  assign flg = {stall_f, stall_d, flush_d, flush_e, stall_emw};

  hazard_ctrl #(.NREG(16), .NRD(2), .PC_REG(15), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rd_addr_d(rd_addr_d), .rd_en_d(rd_en_d),
    .wr_addr_d(wr_addr_d), .wr_en_d(wr_en_d), .mem_to_reg_d(mem_to_reg_d),
    .pc_wr_d(pc_wr_d), .branch_taken_e(branch_taken_e), .mem_wait(mem_wait),
    .clr_cnt(clr_cnt), .fwd_sel(fwd_sel), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .stall_emw(stall_emw), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ra0, ra1;
    logic [1:0] en;
    logic [3:0] wa;
    logic       we, ld, pcw, bt, mw, clr;
    logic [3:0] fwd;
    logic [4:0] flg;   // {stall_f, stall_d, flush_d, flush_e, stall_emw}
    logic [4:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic add(input logic [3:0] ra0, input logic [3:0] ra1, input logic [1:0] en,
                     input logic [3:0] wa, input logic we, input logic ld, input logic pcw,
                     input logic bt, input logic mw, input logic clr,
                     input logic [3:0] fwd, input logic [4:0] f, input logic [4:0] cnt);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.en = en; v.wa = wa; v.we = we; v.ld = ld; v.pcw = pcw;
    v.bt = bt; v.mw = mw; v.clr = clr; v.fwd = fwd; v.flg = f; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rd_addr_d      = {v.ra1, v.ra0};
    rd_en_d        = v.en;
    wr_addr_d      = v.wa;
    wr_en_d        = v.we;
    mem_to_reg_d   = v.ld;
    pc_wr_d        = v.pcw;
    branch_taken_e = v.bt;
    mem_wait       = v.mw;
    clr_cnt        = v.clr;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic nop_in();
    rd_addr_d = '0; rd_en_d = '0; wr_addr_d = '0; wr_en_d = 1'b0; mem_to_reg_d = 1'b0;
    pc_wr_d = 1'b0; branch_taken_e = 1'b0; clr_cnt = 1'b0;
  endtask

  initial begin
    //  ra0 ra1 en    wa  we ld pw bt mw cl  fwd      flags     cnt
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0);  // 0
    add(0,  0,  2'b00, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0);  // 1 ADD R1
    add(1,  0,  2'b01, 2, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0);  // 2 SUB R2,R1
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 5'b00000, 0);  // 3 p0 from M
    add(1,  2,  2'b11, 4, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0);  // 4 reads R1,R2
    add(0,  0,  2'b00, 5, 1, 0, 0, 0, 0, 0, 4'b0100, 5'b00000, 0);  // 5 p1 from W
    add(0,  0,  2'b00, 6, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0);  // 6 ADD R6
    add(0,  0,  2'b00, 6, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0);  // 7 ADD R6
    add(6,  0,  2'b01, 7, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0);  // 8 reads R6
    add(0,  0,  2'b00, 15,1, 0, 0, 0, 0, 0, 4'b0010, 5'b00000, 0);  // 9 M beats W
    add(7,  15, 2'b11, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0);  // 10 reads R7,R15
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 5'b00000, 0);  // 11 R15 not forwarded
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 0);  // 12
    add(0,  0,  2'b00, 3, 1, 1, 0, 0, 0, 0, 4'b0000, 5'b00000, 0);  // 13 LDR R3
    add(0,  3,  2'b10, 8, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b11010, 0);  // 14 load-use
    add(0,  3,  2'b10, 8, 1, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 1);  // 15 bubble
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 5'b00000, 1);  // 16 p1 from W
    add(0,  0,  2'b00, 15,1, 0, 1, 0, 0, 0, 4'b0000, 5'b10100, 1);  // 17 PC write in D
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b10100, 2);  // 18
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b10100, 3);  // 19
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00100, 4);  // 20 W only flushes
    add(0,  0,  2'b00, 15,1, 0, 1, 0, 0, 0, 4'b0000, 5'b00000, 4);  // 21 D invalid
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 4);  // 22
    add(0,  0,  2'b00, 10,1, 0, 0, 1, 0, 0, 4'b0000, 5'b00110, 4);  // 23 taken branch
    add(0,  0,  2'b00, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 5'b00000, 4);  // 24 E invalid
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 4);  // 25
    add(0,  0,  2'b00, 11,1, 1, 0, 0, 0, 0, 4'b0000, 5'b00000, 4);  // 26 LDR R11
    add(11, 0,  2'b01, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 5'b11110, 4);  // 27 ld_stall + bte
    add(11, 0,  2'b01, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 5'b00000, 5);  // 28 D was flushed
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 5);  // 29
    add(0,  0,  2'b00, 12,1, 1, 0, 0, 0, 0, 4'b0000, 5'b00000, 5);  // 30 LDR R12
    add(12, 0,  2'b01, 13,1, 0, 0, 0, 1, 0, 4'b0000, 5'b11001, 5);  // 31 frozen
    add(12, 0,  2'b01, 13,1, 0, 0, 1, 1, 0, 4'b0000, 5'b11001, 6);  // 32 frozen, no flush
    add(12, 0,  2'b01, 13,1, 0, 0, 0, 1, 0, 4'b0000, 5'b11001, 7);  // 33 frozen
    add(12, 0,  2'b01, 13,1, 0, 0, 0, 0, 0, 4'b0000, 5'b11010, 8);  // 34 released
    add(12, 0,  2'b01, 13,1, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 9);  // 35 bubble
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 5'b00000, 9);  // 36 p0 from W
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 5'b00000, 9);  // 37 clear
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 1, 1, 4'b0000, 5'b11001, 0);  // 38 clear beats inc
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 5'b11001, 0);  // 39
    add(0,  0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 5'b00000, 1);  // 40

    reset = 1'b0;
    nop_in();
    mem_wait = 1'b0;
    #12;
    chk("reset_ctl", {fwd_sel, flg}, 9'd0);
    chk("reset_cnt", stall_cnt, 0);
    mem_wait = 1'b1;
    #1;
    chk("reset_memwait", flg, 5'b11001);
    mem_wait = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k]);
      @(negedge clk);
      chk($sformatf("row%0d_ctl", k), {fwd_sel, flg}, {vecs[k].fwd, vecs[k].flg});
      chk($sformatf("row%0d_cnt", k), stall_cnt, vecs[k].cnt);
      @(posedge clk); #1;
    end

    // counter saturates at all-ones
    nop_in();
    mem_wait = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    @(negedge clk);
    chk("sat_cnt", stall_cnt, 31);
    chk("sat_ctl", flg, 5'b11001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sat_hold", stall_cnt, 31);

    // asynchronous reset in the middle of a pending PC write
    @(posedge clk); #1;
    mem_wait = 1'b0;
    pc_wr_d = 1'b1; wr_en_d = 1'b1; wr_addr_d = 4'd15;
    @(negedge clk);
    chk("pre_reset_ctl", flg, 5'b10100);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_reset_ctl", {fwd_sel, flg}, 9'd0);
    chk("mid_reset_cnt", stall_cnt, 0);
    mem_wait = 1'b1;
    #1;
    chk("mid_reset_memwait", flg, 5'b11001);
    reset = 1'b1;
    mem_wait = 1'b0;
    nop_in();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
